// File: rtl/count_step_sched_pkg.sv
// Shared op codes, button FSM state encodings and arbiter grant identifiers
// for the count step scheduler.
package count_step_sched_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic GRANT_BTN  = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

    localparam logic DIR_DN = 1'b0;
    localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/count_step_sched_btn_repeat.sv
// Press detection plus hold-to-repeat FSM shared by the up and down buttons.
// step is combinational so the top can register it alongside the grant.
module count_step_sched_btn_repeat
    import count_step_sched_pkg::*;
#(
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int TIMER_W       = 24
) (
    input  logic clock,
    input  logic rst_n,
    input  logic btn_up_n,
    input  logic btn_dn_n,
    output logic step,
    output logic dir
);

    localparam logic [TIMER_W-1:0] DELAY_LD  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LD = TIMER_W'(REPEAT_PERIOD - 1);

    logic               prev_up;
    logic               prev_dn;
    logic [1:0]         state;
    logic [TIMER_W-1:0] timer;
    logic               dir_q;

    logic press_up;
    logic press_dn;
    logic held;
    logic other;
    logic start_up;
    logic start_dn;

    assign press_up = prev_up & ~btn_up_n;
    assign press_dn = prev_dn & ~btn_dn_n;
    // A fresh press only counts when the other button is fully released.
    assign start_up = press_up & btn_dn_n;
    assign start_dn = press_dn & btn_up_n;
    assign held     = (dir_q == DIR_UP) ? ~btn_up_n : ~btn_dn_n;
    assign other    = (dir_q == DIR_UP) ? ~btn_dn_n : ~btn_up_n;

    always_comb begin
        step = 1'b0;
        dir  = dir_q;
        case (state)
            ST_IDLE: begin
                if (start_up) begin
                    step = 1'b1;
                    dir  = DIR_UP;
                end else if (start_dn) begin
                    step = 1'b1;
                    dir  = DIR_DN;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                step = held & ~other & (timer == '0);
            end
            default: step = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            prev_up <= 1'b0;
            prev_dn <= 1'b0;
            state   <= ST_IDLE;
            timer   <= '0;
            dir_q   <= DIR_DN;
        end else begin
            prev_up <= btn_up_n;
            prev_dn <= btn_dn_n;
            case (state)
                ST_IDLE: begin
                    if (start_up) begin
                        state <= ST_DELAY;
                        dir_q <= DIR_UP;
                        timer <= DELAY_LD;
                    end else if (start_dn) begin
                        state <= ST_DELAY;
                        dir_q <= DIR_DN;
                        timer <= DELAY_LD;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!held || other) begin
                        state <= ST_IDLE;
                    end else if (timer == '0) begin
                        state <= ST_REPEAT;
                        timer <= PERIOD_LD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/count_step_sched.sv
// Display count owner: arbitrates button steps against host commands
// round-robin and applies at most one update per cycle.
module count_step_sched
    import count_step_sched_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int REPEAT_DELAY  = 12_500_000,
    parameter int REPEAT_PERIOD = 2_500_000,
    parameter int TIMER_W       = 24
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             btn_up_n,
    input  logic             btn_dn_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] count,
    output logic             upd,
    output logic             wrap
);

    logic             step;
    logic             step_dir;
    logic             btn_pend;
    logic             btn_dir;
    logic             last_grant;
    logic             grant_btn;
    logic             grant_host;
    logic [1:0]       op;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    count_step_sched_btn_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .TIMER_W       (TIMER_W)
    ) u_btn (
        .clock    (clock),
        .rst_n    (rst_n),
        .btn_up_n (btn_up_n),
        .btn_dn_n (btn_dn_n),
        .step     (step),
        .dir      (step_dir)
    );

    // Under contention the side that did not win last time goes first.
    assign grant_btn  = btn_pend  & (~cmd_valid | (last_grant == GRANT_HOST));
    assign grant_host = cmd_valid & (~btn_pend  | (last_grant == GRANT_BTN));
    assign cmd_ready  = grant_host;

    assign op = grant_btn ? ((btn_dir == DIR_UP) ? OP_INC : OP_DEC) : cmd_op;

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        case (op)
            OP_LOAD:  next_count = cmd_data;
            OP_CLEAR: next_count = '0;
            OP_INC: begin
                next_count = count + 1'b1;
                next_wrap  = (count == '1);
            end
            OP_DEC: begin
                next_count = count - 1'b1;
                next_wrap  = (count == '0);
            end
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            count      <= '0;
            upd        <= 1'b0;
            wrap       <= 1'b0;
            btn_pend   <= 1'b0;
            btn_dir    <= DIR_DN;
            last_grant <= GRANT_HOST;
        end else begin
            upd  <= grant_btn | grant_host;
            wrap <= (grant_btn | grant_host) & next_wrap;
            if (grant_btn || grant_host) begin
                count <= next_count;
            end
            if (grant_btn) begin
                last_grant <= GRANT_BTN;
            end else if (grant_host) begin
                last_grant <= GRANT_HOST;
            end
            // A new step is only accepted when the pending slot is free this cycle.
            if (grant_btn) begin
                btn_pend <= 1'b0;
            end
            if (step && (!btn_pend || grant_btn)) begin
                btn_pend <= 1'b1;
                btn_dir  <= step_dir;
            end
        end
    end

endmodule
